cle_keyseq_serial: RTL and testbench
====================================

Name: cle_keyseq_serial

Overview:
- Parametrised successor to the bus-decoded CLE key-sequence/serial-response PAL.
- Watches qualified read accesses inside an address window and extracts a key field from the address lines on each one.
- Walks a programmable-length key sequence. On a full match, returns a programmable response pattern one bit per qualified read access, MSB first.
- Adds features the fixed-function part lacks: parametrised key/response length and widths, overlap-aware restart, abort on window write, and optional wrap mode.

Parameters:
- ADDR_W, 16, bus address width.
- WIN_LSB, 12, lowest address bit of the window-compare field ba[ADDR_W-1:WIN_LSB].
- WIN_HI, 4'b0001, required value of ba[ADDR_W-1:WIN_LSB].
- KEY_LSB, 4, lowest address bit of the key field.
- KEY_W, 4, key field width.
- KEY_LEN, 4, number of key elements (>=1).
- KEY, 16'h3A5C, KEY_LEN*KEY_W bits; first element is the most-significant KEY_W bits.
- RESP_LEN, 16, response bit count (>=1).
- RESP, 16'hC0A5, response pattern; bit RESP_LEN-1 is sent first.
- WRAP, 0: 1 = stay OPEN and restart the response after the last bit; 0 = return to HUNT.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- acc_stb  in  1  one-cycle pulse per bus access; ba, br_w and sser_n are valid when it is high.
- sser_n  in  1  active-low serial-device select.
- ba  in  ADDR_W  bus address.
- br_w  in  1  1 = read access, 0 = write access.
- sd_out  out  1  response bit, registered.
- sd_oe  out  1  one-cycle pulse: sd_out is valid and the bus driver is enabled.
- unlocked  out  1  high while the state is OPEN.
- key_idx  out  clog2(KEY_LEN+1)  number of key elements matched so far.
- resp_idx  out  clog2(RESP_LEN+1)  number of response bits sent.

Behaviour:
- Decoded signals:
  - hit = acc_stb & ~sser_n & (ba[ADDR_W-1:WIN_LSB]==WIN_HI).
  - qrd = hit & br_w.
  - qwr = hit & ~br_w.
  - fld = ba[KEY_LSB+KEY_W-1:KEY_LSB].
- Reset (synchronous, has priority over every event in the same cycle): state=HUNT, key_idx=0, resp_idx=0, sd_out=0, sd_oe=0, unlocked=0.
- sd_oe defaults to 0 on every cycle. sd_out holds its last value when sd_oe is low.
- State HUNT:
  - qrd with fld==KEY element[key_idx]: key_idx+1. If this was element KEY_LEN-1, go to OPEN with resp_idx=0 and key_idx=0. unlocked rises on the next cycle.
  - qrd with a mismatch: key_idx = (fld==KEY element[0]) ? 1 : 0. This is the overlap restart; for KEY_LEN==1 a match goes straight to OPEN.
  - qwr: key_idx=0.
- State OPEN:
  - qrd: sd_out <= RESP[RESP_LEN-1-resp_idx] and sd_oe <= 1, both visible the cycle after the strobe (latency 1); resp_idx+1. fld is ignored.
  - On the last bit (resp_idx==RESP_LEN-1): if WRAP=1, resp_idx=0 and stay OPEN; if WRAP=0, go to HUNT with resp_idx=0. Either way the last bit is still driven with sd_oe=1.
  - qwr: abort. State=HUNT, resp_idx=0, no sd_oe pulse.
- Ignored inputs:
  - Accesses outside the window, or with sser_n=1, never change state.
  - br_w and ba are ignored when acc_stb=0.
- Back-to-back strobes on consecutive cycles are fully supported: one transition per strobe, with no lost or duplicated response bits.
- Reset mid-sequence or mid-response discards all progress. No partial bit is driven after reset.
- Counter widths use clog2. Indices never exceed KEY_LEN-1 or RESP_LEN-1 at a sampling point.

Test Plan:
- Key unlock and full response: rst, then qrd with fld 3,A,5,C (ba=16'h1030,16'h10A0,16'h1050,16'h10C0) -> unlocked=1, key_idx back to 0. Then 16 qrd -> sd_out sequence 1100000010100101, each bit with a one-cycle sd_oe pulse one cycle after its strobe. After the 16th bit, unlocked=0.
- Overlap restart: fld 3,A,3,A,5,C -> unlock on the 6th access, with key_idx=1 after the 3rd access. Separately, fld 3,7 -> key_idx=0.
- Filtering: key accesses with sser_n=1, or ba=16'h2030 (window miss), or acc_stb=0 -> key_idx stays 0 and unlocked stays 0.
- Abort: unlock, read 5 bits (11000), then one qwr at 16'h1000 -> unlocked=0, resp_idx=0, no sd_oe. A fresh key plus reads restart the response at bit 1 (the first response bit, value 1).
- WRAP=1: unlock, then 20 reads -> bits 1100000010100101 then 1100, and unlocked stays 1.
- Reset priority: rst asserted in the same cycle as the 4th key qrd -> unlocked stays 0 and key_idx=0. rst mid-response -> sd_oe=0 on the next cycle and all counters are 0.

Source files
------------

// File: rtl/cle_keyseq_serial.sv
// cle_keyseq_serial: address-window key-sequence detector that unlocks a serial response stream
module cle_keyseq_serial #(
    parameter int                        ADDR_W   = 16,
    parameter int                        WIN_LSB  = 12,
    parameter logic [ADDR_W-WIN_LSB-1:0] WIN_HI   = 4'b0001,
    parameter int                        KEY_LSB  = 4,
    parameter int                        KEY_W    = 4,
    parameter int                        KEY_LEN  = 4,
    parameter logic [KEY_LEN*KEY_W-1:0]  KEY      = 16'h3A5C,
    parameter int                        RESP_LEN = 16,
    parameter logic [RESP_LEN-1:0]       RESP     = 16'hC0A5,
    parameter bit                        WRAP     = 1'b0,
    localparam int                       KI_W     = $clog2(KEY_LEN + 1),
    localparam int                       RI_W     = $clog2(RESP_LEN + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              acc_stb,
    input  logic              sser_n,
    input  logic [ADDR_W-1:0] ba,
    input  logic              br_w,
    output logic              sd_out,
    output logic              sd_oe,
    output logic              unlocked,
    output logic [KI_W-1:0]   key_idx,
    output logic [RI_W-1:0]   resp_idx
);
    typedef enum logic {HUNT, OPEN} state_t;
    state_t          state_q, state_d;
    logic [KI_W-1:0] key_idx_q, key_idx_d;
    logic [RI_W-1:0] resp_idx_q, resp_idx_d;
    logic            sd_out_q, sd_out_d;
    logic            sd_oe_q, sd_oe_d;
    logic            hit, qrd, qwr;
    logic [KEY_W-1:0] fld;
    logic [KEY_W-1:0] key_el [2**KI_W];
    logic             resp_el [2**RI_W];
    logic             unused_ba;
    // Key elements in match order (element 0 is the most-significant slice); spare slots are zero
    for (genvar i = 0; i < 2**KI_W; i++) begin : g_key
        if (i < KEY_LEN) begin : g_v
            assign key_el[i] = KEY[(KEY_LEN-1-i)*KEY_W +: KEY_W];
        end else begin : g_z
            assign key_el[i] = '0;
        end
    end
    // Response bits in transmit order (index 0 is RESP's MSB); spare slots are zero
    for (genvar i = 0; i < 2**RI_W; i++) begin : g_resp
        if (i < RESP_LEN) begin : g_v
            assign resp_el[i] = RESP[RESP_LEN-1-i];
        end else begin : g_z
            assign resp_el[i] = 1'b0;
        end
    end
    assign hit       = acc_stb & ~sser_n & (ba[ADDR_W-1:WIN_LSB] == WIN_HI);
    assign qrd       = hit & br_w;
    assign qwr       = hit & ~br_w;
    assign fld       = ba[KEY_LSB+KEY_W-1:KEY_LSB];
    assign unused_ba = ^ba;
    assign sd_out    = sd_out_q;
    assign sd_oe     = sd_oe_q;
    assign unlocked  = (state_q == OPEN);
    assign key_idx   = key_idx_q;
    assign resp_idx  = resp_idx_q;
    // Next state: key walk with overlap restart in HUNT, bit-serial response and write abort in OPEN
    always_comb begin
        state_d    = state_q;
        key_idx_d  = key_idx_q;
        resp_idx_d = resp_idx_q;
        sd_out_d   = sd_out_q;
        sd_oe_d    = 1'b0;
        if (state_q == HUNT) begin
            if (qrd) begin
                if (fld == key_el[key_idx_q]) begin
                    if (key_idx_q == KI_W'(KEY_LEN - 1)) begin
                        state_d    = OPEN;
                        key_idx_d  = '0;
                        resp_idx_d = '0;
                    end else begin
                        key_idx_d = key_idx_q + KI_W'(1);
                    end
                end else begin
                    key_idx_d = (fld == key_el[0]) ? KI_W'(1) : '0;
                end
            end else if (qwr) begin
                key_idx_d = '0;
            end
        end else begin
            if (qrd) begin
                sd_out_d = resp_el[resp_idx_q];
                sd_oe_d  = 1'b1;
                if (resp_idx_q == RI_W'(RESP_LEN - 1)) begin
                    resp_idx_d = '0;
                    state_d    = WRAP ? OPEN : HUNT;
                end else begin
                    resp_idx_d = resp_idx_q + RI_W'(1);
                end
            end else if (qwr) begin
                state_d    = HUNT;
                resp_idx_d = '0;
            end
        end
    end
    // State register; reset wins over any access in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= HUNT;
            key_idx_q  <= '0;
            resp_idx_q <= '0;
            sd_out_q   <= 1'b0;
            sd_oe_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_idx_q  <= key_idx_d;
            resp_idx_q <= resp_idx_d;
            sd_out_q   <= sd_out_d;
            sd_oe_q    <= sd_oe_d;
        end
    end
endmodule

// File: tb/tb_cle_keyseq_serial.sv
// tb_cle_keyseq_serial: directed bench with a response-bit scoreboard for a no-wrap and a wrap instance
module tb_cle_keyseq_serial;
    localparam logic [15:0] RESP_C = 16'hC0A5;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        acc_stb = 1'b0;
    logic        sser_n = 1'b1;
    logic [15:0] ba = '0;
    logic        br_w = 1'b0;
    logic        sd_out0, sd_oe0, unl0, sd_out1, sd_oe1, unl1;
    logic [2:0]  kidx0, kidx1;
    logic [4:0]  ridx0, ridx1;
    logic        q0[$];
    logic        q1[$];
    int          errs = 0;
    int          checks = 0;
    cle_keyseq_serial dut0 (
        .clk(clk), .rst(rst), .acc_stb(acc_stb), .sser_n(sser_n), .ba(ba), .br_w(br_w),
        .sd_out(sd_out0), .sd_oe(sd_oe0), .unlocked(unl0), .key_idx(kidx0), .resp_idx(ridx0)
    );
    cle_keyseq_serial #(.WRAP(1'b1)) dut1 (
        .clk(clk), .rst(rst), .acc_stb(acc_stb), .sser_n(sser_n), .ba(ba), .br_w(br_w),
        .sd_out(sd_out1), .sd_oe(sd_oe1), .unlocked(unl1), .key_idx(kidx1), .resp_idx(ridx1)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic pop_chk();
        logic e;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            chk("oe0", 32'(sd_oe0), 32'd1);
            chk("bit0", 32'(sd_out0), 32'(e));
        end else chk("oe0_idle", 32'(sd_oe0), 32'd0);
        if (q1.size() != 0) begin
            e = q1.pop_front();
            chk("oe1", 32'(sd_oe1), 32'd1);
            chk("bit1", 32'(sd_out1), 32'(e));
        end else chk("oe1_idle", 32'(sd_oe1), 32'd0);
    endtask
    task automatic strobe(input logic [15:0] a, input logic rw, input logic sn, input logic stb);
        acc_stb = stb; ba = a; br_w = rw; sser_n = sn;
        @(negedge clk);
        acc_stb = 1'b0;
        pop_chk();
    endtask
    task automatic key(input logic [3:0] f);
        strobe({8'h10, f, 4'h0}, 1'b1, 1'b0, 1'b1);
    endtask
    task automatic unlock();
        key(4'h3); key(4'hA); key(4'h5); key(4'hC);
    endtask
    task automatic rd_bits(input int n, input int start, input bit p0, input bit p1);
        for (int k = 0; k < n; k++) begin
            if (p0) q0.push_back(RESP_C[15 - ((start + k) % 16)]);
            if (p1) q1.push_back(RESP_C[15 - ((start + k) % 16)]);
            strobe(16'h1000, 1'b1, 1'b0, 1'b1);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1; acc_stb = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q0.delete(); q1.delete();
        chk("rst_unl", 32'(unl0), 32'd0);
        chk("rst_kidx", 32'(kidx0), 32'd0);
        chk("rst_ridx", 32'(ridx0), 32'd0);
        chk("rst_oe", 32'(sd_oe0), 32'd0);
        chk("rst_out", 32'(sd_out0), 32'd0);
    endtask
    initial begin
        repeat (2) @(negedge clk);
        do_reset();
        key(4'h3); key(4'hA); key(4'h5);
        chk("kidx3", 32'(kidx0), 32'd3);
        chk("unl_pre", 32'(unl0), 32'd0);
        key(4'hC);
        chk("unl_open", 32'(unl0), 32'd1);
        chk("kidx_open", 32'(kidx0), 32'd0);
        rd_bits(16, 0, 1'b1, 1'b1);
        chk("unl_done", 32'(unl0), 32'd0);
        chk("ridx_done", 32'(ridx0), 32'd0);
        strobe(16'h0000, 1'b0, 1'b1, 1'b0);
        chk("hold_out", 32'(sd_out0), 32'd1);
        do_reset();
        key(4'h3); key(4'hA); key(4'h3);
        chk("ovl_kidx", 32'(kidx0), 32'd1);
        key(4'hA); key(4'h5);
        chk("ovl_unl5", 32'(unl0), 32'd0);
        key(4'hC);
        chk("ovl_unl6", 32'(unl0), 32'd1);
        do_reset();
        key(4'h3); key(4'h7);
        chk("miss_kidx", 32'(kidx0), 32'd0);
        do_reset();
        strobe(16'h1030, 1'b1, 1'b1, 1'b1);
        chk("flt_sser", 32'(kidx0), 32'd0);
        strobe(16'h2030, 1'b1, 1'b0, 1'b1);
        chk("flt_win", 32'(kidx0), 32'd0);
        strobe(16'h1030, 1'b1, 1'b0, 1'b0);
        chk("flt_stb", 32'(kidx0), 32'd0);
        strobe(16'h10A0, 1'b1, 1'b1, 1'b1);
        strobe(16'h1050, 1'b1, 1'b1, 1'b1);
        strobe(16'h10C0, 1'b1, 1'b1, 1'b1);
        chk("flt_unl", 32'(unl0), 32'd0);
        key(4'h3);
        strobe(16'h1000, 1'b0, 1'b0, 1'b1);
        chk("hunt_wr", 32'(kidx0), 32'd0);
        do_reset();
        unlock();
        rd_bits(5, 0, 1'b1, 1'b1);
        chk("ab_ridx5", 32'(ridx0), 32'd5);
        strobe(16'h1000, 1'b0, 1'b0, 1'b1);
        chk("ab_unl", 32'(unl0), 32'd0);
        chk("ab_ridx", 32'(ridx0), 32'd0);
        unlock();
        rd_bits(1, 0, 1'b1, 1'b1);
        chk("ab_ridx1", 32'(ridx0), 32'd1);
        do_reset();
        unlock();
        rd_bits(16, 0, 1'b1, 1'b1);
        rd_bits(4, 16, 1'b0, 1'b1);
        chk("wr_unl1", 32'(unl1), 32'd1);
        chk("wr_ridx1", 32'(ridx1), 32'd4);
        chk("wr_unl0", 32'(unl0), 32'd0);
        do_reset();
        key(4'h3); key(4'hA); key(4'h5);
        rst = 1'b1;
        key(4'hC);
        rst = 1'b0;
        chk("rp_unl", 32'(unl0), 32'd0);
        chk("rp_kidx", 32'(kidx0), 32'd0);
        unlock();
        rd_bits(3, 0, 1'b1, 1'b1);
        rst = 1'b1;
        strobe(16'h1000, 1'b1, 1'b0, 1'b1);
        rst = 1'b0;
        chk("rm_unl", 32'(unl0), 32'd0);
        chk("rm_ridx", 32'(ridx0), 32'd0);
        chk("rm_kidx", 32'(kidx0), 32'd0);
        chk("rm_unl1", 32'(unl1), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
